// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer RAM arbiter.
package fb_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 16;

  // Arbitration outcome for one RAM cycle.
  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_WR   = 2'd1,
    GRANT_RD   = 2'd2
  } fb_grant_e;

  // One buffered camera write: address in the upper bits, pixel below.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO that absorbs camera writes while the RAM serves reads.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fb_wr_entry_t din_i,
  output fb_wr_entry_t dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [LW-1:0] level_o
);

  fb_wr_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rptr_q];

  // Full blocks a push even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy tracks the push/pop pair; simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Entry storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/fb_ram_arbiter.sv
// Shares the frame-buffer SPRAM between the buffered camera write path and
// the valid/ready readout path. Writes win when the FIFO nears full;
// otherwise grants alternate under contention.
module fb_ram_arbiter
  import fb_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  parameter  int HI_WATER   = 3,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [FB_DATA_W-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 wr_overflow,
  output logic [LVL_W-1:0]     fifo_level,
  input  logic                 rd_valid,
  input  logic [FB_ADDR_W-1:0] rd_addr,
  output logic                 rd_ready,
  output logic [FB_DATA_W-1:0] rd_data,
  output logic                 rd_data_valid,
  output logic [FB_ADDR_W-1:0] ram_address,
  output logic [FB_DATA_W-1:0] ram_data_in,
  output logic                 ram_write_en,
  input  logic [FB_DATA_W-1:0] ram_data_out
);

  // One extra bit so a threshold above the depth (level priority disabled) still fits.
  localparam logic [LVL_W:0] HI_LVL = (LVL_W + 1)'(HI_WATER);

  fb_wr_entry_t wr_entry, head;
  logic         fifo_full, fifo_empty, push, pop;
  fb_grant_e    grant, last_grant_q, last_grant_d;
  logic         rd_pending_q, rd_pending_d;
  logic         wr_overflow_q, wr_overflow_d;

  assign wr_entry.addr = wr_addr;
  assign wr_entry.data = wr_data;
  assign push          = wr_valid && !fifo_full;
  assign pop           = (grant == GRANT_WR);
  assign wr_ready      = !fifo_full;
  assign wr_overflow   = wr_overflow_q;
  assign rd_data_valid = rd_pending_q;
  assign rd_data       = ram_data_out;

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (wr_entry),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Pick this cycle's RAM owner from registered FIFO state and the read request.
  always_comb begin
    grant = GRANT_IDLE;
    if (!fifo_empty &&
        (({1'b0, fifo_level} >= HI_LVL) || !rd_valid || (last_grant_q == GRANT_RD)))
      grant = GRANT_WR;
    else if (rd_valid)
      grant = GRANT_RD;
  end

  // Drive the RAM port for the winner and compute next fairness/pending/overflow state.
  always_comb begin
    ram_address   = '0;
    ram_data_in   = '0;
    ram_write_en  = 1'b0;
    rd_ready      = 1'b0;
    last_grant_d  = last_grant_q;
    rd_pending_d  = 1'b0;
    wr_overflow_d = wr_overflow_q || (wr_valid && fifo_full);
    case (grant)
      GRANT_WR: begin
        ram_address  = head.addr;
        ram_data_in  = head.data;
        ram_write_en = 1'b1;
        last_grant_d = GRANT_WR;
      end
      GRANT_RD: begin
        ram_address  = rd_addr;
        rd_ready     = 1'b1;
        last_grant_d = GRANT_RD;
        rd_pending_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Resetting last grant to READ hands the first contended cycle to the camera.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= GRANT_RD;
      rd_pending_q  <= 1'b0;
      wr_overflow_q <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      rd_pending_q  <= rd_pending_d;
      wr_overflow_q <= wr_overflow_d;
    end
  end

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Scoreboard bench for fb_ram_arbiter: directed cycle tables drive the inputs and
// queue the expected RAM writes / read data; monitors pop and compare.
module tb_fb_ram_arbiter;
  import fb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // main instance (HI_WATER=3)
  logic        wr_valid, wr_ready, wr_overflow, rd_valid, rd_ready, rd_data_valid, ram_write_en;
  logic [16:0] wr_addr, rd_addr, ram_address;
  logic [15:0] wr_data, rd_data, ram_data_in, ram_data_out;
  logic [2:0]  fifo_level;
  // overflow instance (HI_WATER=5, level priority disabled)
  logic        o_wr_valid, o_wr_ready, o_wr_overflow, o_rd_valid, o_rd_ready, o_rd_data_valid, o_ram_write_en;
  logic [16:0] o_wr_addr, o_rd_addr, o_ram_address;
  logic [15:0] o_wr_data, o_rd_data, o_ram_data_in, o_ram_data_out;
  logic [2:0]  o_fifo_level;

  fb_ram_arbiter #(.FIFO_DEPTH(DEPTH), .HI_WATER(3)) u_dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_overflow(wr_overflow), .fifo_level(fifo_level),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_en(ram_write_en), .ram_data_out(ram_data_out));

  fb_ram_arbiter #(.FIFO_DEPTH(DEPTH), .HI_WATER(5)) u_ovf (
    .clk(clk), .reset(reset), .wr_valid(o_wr_valid), .wr_addr(o_wr_addr), .wr_data(o_wr_data),
    .wr_ready(o_wr_ready), .wr_overflow(o_wr_overflow), .fifo_level(o_fifo_level),
    .rd_valid(o_rd_valid), .rd_addr(o_rd_addr), .rd_ready(o_rd_ready), .rd_data(o_rd_data),
    .rd_data_valid(o_rd_data_valid), .ram_address(o_ram_address), .ram_data_in(o_ram_data_in),
    .ram_write_en(o_ram_write_en), .ram_data_out(o_ram_data_out));

  // RAM models: 1-cycle read latency
  logic [15:0] mem  [0:131071];
  logic [15:0] omem [0:131071];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
    if (o_ram_write_en) omem[o_ram_address] <= o_ram_data_in;
    o_ram_data_out <= omem[o_ram_address];
  end

  int nchk = 0;
  int nerr = 0;
  logic [32:0] exp_wr0[$];
  logic [32:0] exp_wr1[$];
  logic [15:0] exp_rd[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write monitors: every RAM write must be the next expected entry.
  always @(negedge clk) begin
    if (ram_write_en) begin
      if (exp_wr0.size() == 0) chk("wr_unexpected", {15'd0, ram_address}, 32'hFFFF_FFFF);
      else begin
        logic [32:0] e;
        e = exp_wr0.pop_front();
        chk("wr_addr", {15'd0, ram_address}, {15'd0, e[32:16]});
        chk("wr_data", {16'd0, ram_data_in}, {16'd0, e[15:0]});
      end
    end
    if (rd_data_valid) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", {16'd0, rd_data}, 32'hFFFF_FFFF);
      else chk("rd_data", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (o_ram_write_en) begin
      if (exp_wr1.size() == 0) chk("ovf_wr_unexpected", {15'd0, o_ram_address}, 32'hFFFF_FFFF);
      else begin
        logic [32:0] e;
        e = exp_wr1.pop_front();
        chk("ovf_wr_addr", {15'd0, o_ram_address}, {15'd0, e[32:16]});
        chk("ovf_wr_data", {16'd0, o_ram_data_in}, {16'd0, e[15:0]});
      end
    end
  end

  typedef struct {
    bit rst; bit wv; bit wk; logic [16:0] wa; logic [15:0] wd;
    bit rv; logic [16:0] ra;
    bit e_rdy; bit e_we; int e_lvl; bit e_ovf; logic [15:0] e_rd;
  } vec_t;

  function automatic vec_t mk(bit rst, bit wv, bit wk, logic [16:0] wa, logic [15:0] wd,
                              bit rv, logic [16:0] ra, bit rdy, bit we, int lvl, bit ovf,
                              logic [15:0] rd);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wk = wk; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
    v.e_rdy = rdy; v.e_we = we; v.e_lvl = lvl; v.e_ovf = ovf; v.e_rd = rd;
    return v;
  endfunction

  function automatic vec_t idle(int lvl, bit ovf);
    return mk(0, 0, 0, 17'd0, 16'd0, 0, 17'd0, 0, 0, lvl, ovf, 16'd0);
  endfunction

  // Apply one row per cycle: drive after the edge, check at the falling edge.
  task automatic run(input bit sel, input vec_t tv[$]);
    bit prev_rdy = 1'b0;
    bit prev_rst = 1'b0;
    foreach (tv[i]) begin
      vec_t r;
      logic rdy, we, dv, ovf, wrdy;
      logic [2:0] lvl;
      logic [16:0] addr;
      logic [15:0] din;
      r = tv[i];
      @(posedge clk); #1;
      reset = r.rst;
      if (sel) begin
        o_wr_valid = r.wv; o_wr_addr = r.wa; o_wr_data = r.wd; o_rd_valid = r.rv; o_rd_addr = r.ra;
      end else begin
        wr_valid = r.wv; wr_addr = r.wa; wr_data = r.wd; rd_valid = r.rv; rd_addr = r.ra;
      end
      @(negedge clk);
      rdy  = sel ? o_rd_ready      : rd_ready;
      we   = sel ? o_ram_write_en  : ram_write_en;
      dv   = sel ? o_rd_data_valid : rd_data_valid;
      ovf  = sel ? o_wr_overflow   : wr_overflow;
      wrdy = sel ? o_wr_ready      : wr_ready;
      lvl  = sel ? o_fifo_level    : fifo_level;
      addr = sel ? o_ram_address   : ram_address;
      din  = sel ? o_ram_data_in   : ram_data_in;
      chk("fifo_level", {29'd0, lvl}, r.e_lvl);
      chk("wr_ready", {31'd0, wrdy}, {31'd0, (r.e_lvl != DEPTH)});
      chk("rd_ready", {31'd0, rdy}, {31'd0, r.e_rdy});
      chk("ram_write_en", {31'd0, we}, {31'd0, r.e_we});
      chk("rd_data_valid", {31'd0, dv}, {31'd0, prev_rdy && !prev_rst});
      chk("wr_overflow", {31'd0, ovf}, {31'd0, r.e_ovf});
      if (r.e_rdy) chk("rd_ram_addr", {15'd0, addr}, {15'd0, r.ra});
      if (!r.e_rdy && !r.e_we) begin
        chk("idle_addr", {15'd0, addr}, 32'd0);
        chk("idle_din", {16'd0, din}, 32'd0);
      end
      if (r.wk) begin
        if (sel) exp_wr1.push_back({r.wa, r.wd});
        else     exp_wr0.push_back({r.wa, r.wd});
      end
      if (r.e_rdy && !r.rst && !sel) exp_rd.push_back(r.e_rd);
      prev_rdy = r.e_rdy;
      prev_rst = r.rst;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t m[$];
    vec_t o[$];
    mem[17'h08000] = 16'h5A5A;
    for (int k = 0; k < 5; k++) mem[17'h00100 + 17'(k)] = 16'h1100 + 16'(k);
    reset = 1'b1;
    wr_valid = 0; wr_addr = '0; wr_data = '0; rd_valid = 0; rd_addr = '0;
    o_wr_valid = 0; o_wr_addr = '0; o_wr_data = '0; o_rd_valid = 0; o_rd_addr = '0;
    repeat (3) @(posedge clk);

    // write only (first row also checks the reset state)
    m.push_back(mk(0,1,1,17'h00010,16'hABCD,0,17'h0, 0,0,0,0,16'h0));
    m.push_back(mk(0,1,1,17'h1FFFF,16'h1234,0,17'h0, 0,1,1,0,16'h0));
    m.push_back(idle(1,0)); m[$].e_we = 1;
    m.push_back(idle(0,0));
    // read latency
    m.push_back(mk(0,0,0,17'h0,16'h0,1,17'h08000, 1,0,0,0,16'h5A5A));
    m.push_back(idle(0,0));
    m.push_back(idle(0,0));
    // contention below high water: W R W R W R
    m.push_back(mk(0,1,1,17'h00200,16'h7701,0,17'h0,     0,0,0,0,16'h0));
    m.push_back(mk(0,1,1,17'h00201,16'h7702,1,17'h00100, 0,1,1,0,16'h0));
    m.push_back(mk(0,0,0,17'h0,16'h0,       1,17'h00100, 1,0,1,0,16'h1100));
    m.push_back(mk(0,1,1,17'h00202,16'h7703,1,17'h00101, 0,1,1,0,16'h0));
    m.push_back(mk(0,0,0,17'h0,16'h0,       1,17'h00101, 1,0,1,0,16'h1101));
    m.push_back(mk(0,0,0,17'h0,16'h0,       1,17'h00102, 0,1,1,0,16'h0));
    m.push_back(mk(0,0,0,17'h0,16'h0,       1,17'h00102, 1,0,0,0,16'h1102));
    m.push_back(idle(0,0));
    // high water: consecutive writes at level 3 with read held
    m.push_back(mk(0,1,1,17'h00301,16'h8801,1,17'h00104, 1,0,0,0,16'h1104));
    m.push_back(mk(0,1,1,17'h00302,16'h8802,1,17'h00104, 0,1,1,0,16'h0));
    m.push_back(mk(0,1,1,17'h00303,16'h8803,1,17'h00104, 1,0,1,0,16'h1104));
    m.push_back(mk(0,1,1,17'h00304,16'h8804,1,17'h00104, 0,1,2,0,16'h0));
    m.push_back(mk(0,1,1,17'h00305,16'h8805,1,17'h00104, 1,0,2,0,16'h1104));
    m.push_back(mk(0,1,1,17'h00306,16'h8806,1,17'h00104, 0,1,3,0,16'h0));
    m.push_back(mk(0,0,0,17'h0,16'h0,       1,17'h00104, 0,1,3,0,16'h0));
    m.push_back(mk(0,0,0,17'h0,16'h0,       1,17'h00104, 1,0,2,0,16'h1104));
    m.push_back(idle(2,0)); m[$].e_we = 1;
    m.push_back(idle(1,0)); m[$].e_we = 1;
    m.push_back(idle(0,0));
    // reset with level 2 and a read granted in the same cycle
    m.push_back(mk(0,1,1,17'h00401,16'h9901,1,17'h00103, 1,0,0,0,16'h1103));
    m.push_back(mk(0,1,1,17'h00402,16'h9902,1,17'h00103, 0,1,1,0,16'h0));
    m.push_back(mk(0,1,0,17'h00403,16'h9903,1,17'h00103, 1,0,1,0,16'h1103));
    m.push_back(mk(0,1,0,17'h00404,16'h9904,1,17'h00103, 0,1,2,0,16'h0));
    m.push_back(mk(1,0,0,17'h0,16'h0,       1,17'h00103, 1,0,2,0,16'h0));
    m.push_back(idle(0,0));
    m.push_back(idle(0,0));
    run(1'b0, m);

    // overflow on the HI_WATER=5 instance: reads keep the FIFO filling
    for (int k = 1; k <= 7; k++)
      o.push_back(mk(0,1,1,17'h00500 + 17'(k),16'hD000 + 16'(k),1,17'h00100,
                     (k % 2) == 1, (k % 2) == 0, k / 2, 0, 16'h0));
    o.push_back(mk(0,1,0,17'h00508,16'hD008,1,17'h00100, 0,1,4,0,16'h0));
    o.push_back(idle(3,1)); o[$].e_we = 1;
    o.push_back(idle(2,1)); o[$].e_we = 1;
    o.push_back(idle(1,1)); o[$].e_we = 1;
    o.push_back(idle(0,1));
    o.push_back(idle(0,1)); o[$].rst = 1;
    o.push_back(idle(0,0));
    run(1'b1, o);

    repeat (3) @(negedge clk);
    chk("wr_queue_drained", exp_wr0.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("ovf_wr_queue_drained", exp_wr1.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
